// File: rtl/axis_interp_pkg.sv
// Shared types and default parameters for the linear interpolator.
package axis_interp_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_LOG2_RATE = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

endpackage

// File: rtl/interp_lerp_core.sv
// Combinational lerp: y = x0 + ((k * (x1 - x0)) >>> LOG2_RATE), floor rounding.
module interp_lerp_core #(
    parameter int WIDTH     = 16,
    parameter int LOG2_RATE = 2
) (
    input  logic [WIDTH-1:0]     x0,
    input  logic [WIDTH-1:0]     x1,
    input  logic [LOG2_RATE-1:0] k,
    output logic [WIDTH-1:0]     y
);

    localparam int PW = WIDTH + 1 + LOG2_RATE;

    logic signed [WIDTH:0]  diff;
    logic signed [PW-1:0]   diff_ext;
    logic signed [PW-1:0]   k_ext;
    logic signed [PW-1:0]   x0_ext;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   shifted;

    always_comb begin
        diff     = $signed({x1[WIDTH-1], x1}) - $signed({x0[WIDTH-1], x0});
        diff_ext = {{LOG2_RATE{diff[WIDTH]}}, diff};
        k_ext    = $signed({{(WIDTH + 1){1'b0}}, k});
        x0_ext   = $signed({{(LOG2_RATE + 1){x0[WIDTH-1]}}, x0});
        // |k*diff| < 2**(WIDTH+LOG2_RATE), so PW bits hold the product exactly
        prod     = k_ext * diff_ext;
        shifted  = prod >>> LOG2_RATE;
    end

    // Result lies between x0 and x1, so truncation never wraps
    assign y = WIDTH'(x0_ext + shifted);

endmodule

// File: rtl/axis_interp_lin.sv
// AXI-Stream linear interpolator: R = 2**LOG2_RATE output beats per input sample.
// Handshakes: a beat transfers on a rising edge where tvalid and tready are both 1.
module axis_interp_lin
    import axis_interp_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int LOG2_RATE = DEF_LOG2_RATE
) (
    input  logic             aclk,
    input  logic             arst,
    input  logic [WIDTH-1:0] s_axis_data_tdata,
    input  logic             s_axis_data_tvalid,
    output logic             s_axis_data_tready,
    output logic [WIDTH-1:0] m_axis_data_tdata,
    output logic             m_axis_data_tvalid,
    input  logic             m_axis_data_tready,
    output logic [1:0]       dbg_state
);

    localparam logic [LOG2_RATE-1:0] K_LAST = '1;

    state_t               state, state_next;
    logic [WIDTH-1:0]     x0, x1, pend;
    logic [LOG2_RATE-1:0] k;
    logic                 pend_valid;

    logic in_hs, out_hs;
    logic load_first, inc_k, shift_pend, shift_din, load_pend;

    assign s_axis_data_tready = !pend_valid;
    assign m_axis_data_tvalid = (state == RUN);
    assign dbg_state          = state;

    assign in_hs  = s_axis_data_tvalid && s_axis_data_tready;
    assign out_hs = m_axis_data_tvalid && m_axis_data_tready;

    always_ff @(posedge aclk) begin
        if (arst) begin
            state      <= IDLE;
            x0         <= '0;
            x1         <= '0;
            k          <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (load_first) begin
                x0 <= s_axis_data_tdata;
                x1 <= s_axis_data_tdata;
                k  <= '0;
            end else if (shift_pend) begin
                x0         <= x1;
                x1         <= pend;
                k          <= '0;
                pend_valid <= 1'b0;
            end else if (shift_din) begin
                x0 <= x1;
                x1 <= s_axis_data_tdata;
                k  <= '0;
            end else if (inc_k) begin
                k <= k + LOG2_RATE'(1);
            end
            if (load_pend) begin
                pend       <= s_axis_data_tdata;
                pend_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        load_first = 1'b0;
        inc_k      = 1'b0;
        shift_pend = 1'b0;
        shift_din  = 1'b0;
        load_pend  = 1'b0;
        case (state)
            IDLE: begin
                if (in_hs) begin
                    load_first = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (out_hs) begin
                    if (k != K_LAST) begin
                        inc_k = 1'b1;
                    end else if (pend_valid) begin
                        shift_pend = 1'b1;
                    end else if (in_hs) begin
                        shift_din = 1'b1;
                    end else begin
                        state_next = STALL;
                    end
                end
                // A sample not consumed at the segment boundary is parked in pend
                load_pend = in_hs && !shift_din;
            end
            STALL: begin
                if (in_hs) begin
                    shift_din  = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    interp_lerp_core #(
        .WIDTH     (WIDTH),
        .LOG2_RATE (LOG2_RATE)
    ) u_lerp (
        .x0 (x0),
        .x1 (x1),
        .k  (k),
        .y  (m_axis_data_tdata)
    );

endmodule

// File: tb/tb_axis_interp_lin.sv
// Directed bench for axis_interp_lin (WIDTH=16, LOG2_RATE=2).
module tb_axis_interp_lin;

    logic               aclk = 1'b0;
    logic               arst = 1'b0;
    logic signed [15:0] s_tdata = '0;
    logic               s_tvalid = 1'b0;
    logic               s_tready;
    logic signed [15:0] m_tdata;
    logic               m_tvalid;
    logic               m_tready = 1'b1;
    logic [1:0]         dbg_state;

    int checks   = 0;
    int failures = 0;

    logic signed [31:0] got_q[$];
    int cyc_cnt     = 0;
    int first_valid = -1;
    int last_valid  = -1;
    int n_valid     = 0;

    axis_interp_lin #(.WIDTH(16), .LOG2_RATE(2)) dut (
        .aclk               (aclk),
        .arst               (arst),
        .s_axis_data_tdata  (s_tdata),
        .s_axis_data_tvalid (s_tvalid),
        .s_axis_data_tready (s_tready),
        .m_axis_data_tdata  (m_tdata),
        .m_axis_data_tvalid (m_tvalid),
        .m_axis_data_tready (m_tready),
        .dbg_state          (dbg_state)
    );

    always #5 aclk = ~aclk;

    // Output monitor: inputs only change #1 after posedge, so negedge values hold to the next edge
    always @(negedge aclk) begin
        cyc_cnt++;
        if (!arst && m_tvalid) begin
            if (first_valid < 0) first_valid = cyc_cnt;
            last_valid = cyc_cnt;
            n_valid++;
            if (m_tready) got_q.push_back(32'(m_tdata));
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        first_valid = -1;
        last_valid  = -1;
        n_valid     = 0;
    endtask

    task automatic do_reset();
        arst     = 1'b1;
        s_tvalid = 1'b0;
        repeat (2) cyc();
        arst = 1'b0;
    endtask

    task automatic send(input logic signed [15:0] d);
        int n;
        n        = 0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_tready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        chk("send_ready", 32'(s_tready), 1);
        @(posedge aclk);
        #1;
    endtask

    task automatic check_q(input string tag, input logic signed [31:0] e[$]);
        chk({tag, "_count"}, got_q.size(), e.size());
        for (int i = 0; i < e.size(); i++) begin
            if (i < got_q.size()) chk($sformatf("%s_%0d", tag, i), got_q[i], e[i]);
            else                  chk($sformatf("%s_%0d", tag, i), 'x, e[i]);
        end
    endtask

    task automatic run_seg(input string tag, input logic signed [15:0] a, input logic signed [15:0] b,
                           input logic signed [31:0] e[$]);
        m_tready = 1'b1;
        do_reset();
        clear_mon();
        send(a);
        send(b);
        s_tvalid = 1'b0;
        repeat (12) cyc();
        check_q(tag, e);
    endtask

    initial begin
        // Reset and idle behaviour
        m_tready = 1'b1;
        do_reset();
        chk("rst_tvalid", 32'(m_tvalid), 0);
        chk("rst_tdata", 32'(m_tdata), 0);
        chk("rst_tready", 32'(s_tready), 1);
        chk("rst_state", 32'(dbg_state), 0);
        clear_mon();
        repeat (3) cyc();
        chk("idle_no_output", n_valid, 0);

        // Back-to-back 100, 200, 300
        clear_mon();
        send(16'sd100);
        send(16'sd200);
        send(16'sd300);
        s_tvalid = 1'b0;
        repeat (20) cyc();
        check_q("ramp", '{100, 100, 100, 100, 100, 125, 150, 175, 200, 225, 250, 275});
        chk("ramp_nvalid", n_valid, 12);
        chk("ramp_no_bubble", last_valid - first_valid + 1, n_valid);

        // STALL, then resume with prior x1 at k=0
        chk("stall_tvalid", 32'(m_tvalid), 0);
        chk("stall_state", 32'(dbg_state), 2);
        clear_mon();
        send(16'sd500);
        chk("resume_tvalid", 32'(m_tvalid), 1);
        chk("resume_tdata", 32'(m_tdata), 300);
        s_tvalid = 1'b0;
        repeat (10) cyc();
        check_q("resume", '{300, 350, 400, 450});

        // Segment arithmetic corners
        run_seg("seg_down", 16'sd200, -16'sd200, '{200, 200, 200, 200, 200, 100, 0, -100});
        run_seg("seg_floor", 16'sd0, -16'sd1, '{0, 0, 0, 0, 0, -1, -1, -1});
        run_seg("seg_full", -16'sd32768, 16'sd32767,
                '{-32768, -32768, -32768, -32768, -32768, -16385, -1, 16383});

        // Backpressure at k=2 with a pending sample
        m_tready = 1'b0;
        do_reset();
        send(16'sd0);
        send(16'sd400);
        s_tvalid = 1'b0;
        chk("bp_pend_tready", 32'(s_tready), 0);
        m_tready = 1'b1;
        repeat (4) cyc();
        chk("bp_seg_k0", 32'(m_tdata), 0);
        chk("bp_seg_tready", 32'(s_tready), 1);
        repeat (2) cyc();
        chk("bp_k2", 32'(m_tdata), 200);
        m_tready = 1'b0;
        s_tdata  = 16'sd600;
        s_tvalid = 1'b1;
        cyc();
        s_tvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_hold_data_%0d", i), 32'(m_tdata), 200);
            chk($sformatf("bp_hold_valid_%0d", i), 32'(m_tvalid), 1);
            chk($sformatf("bp_hold_tready_%0d", i), 32'(s_tready), 0);
            if (i < 2) cyc();
        end
        m_tready = 1'b1;
        cyc();
        chk("bp_k3", 32'(m_tdata), 300);
        chk("bp_k3_tready", 32'(s_tready), 0);
        cyc();
        chk("bp_next_k0", 32'(m_tdata), 400);
        chk("bp_next_tready", 32'(s_tready), 1);

        // Reset mid-segment with pend full
        m_tready = 1'b1;
        do_reset();
        send(16'sd10);
        send(16'sd20);
        s_tvalid = 1'b0;
        chk("mid_pend_tready", 32'(s_tready), 0);
        arst = 1'b1;
        cyc();
        arst = 1'b0;
        chk("mid_rst_tvalid", 32'(m_tvalid), 0);
        chk("mid_rst_tdata", 32'(m_tdata), 0);
        chk("mid_rst_tready", 32'(s_tready), 1);
        chk("mid_rst_state", 32'(dbg_state), 0);
        repeat (3) cyc();
        clear_mon();
        send(16'sd7);
        s_tvalid = 1'b0;
        repeat (10) cyc();
        check_q("post_rst", '{7, 7, 7, 7});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
